// File: rtl/seq_adder_accum.sv
// seq_adder_accum: multi-cycle signed add/sub/accumulate, CHUNK bits per clock
// with a registered carry between chunks and valid/ready handshakes.
//
// Ports:
//   clk, rst              - single clock, synchronous active-high reset
//   in_valid/in_ready     - operation handshake (a, b, mode)
//   mode                  - 00 a+b, 01 a-b, 10 acc+a, 11 clear accumulator
//   out_valid/out_ready   - result handshake (f, ovf)
//   acc                   - current accumulator value
//
// Option: define SEQ_ADDER_ACCUM_SATURATE_EN to saturate f (and acc in mode
// 10) on signed overflow; the default build wraps modulo 2^WIDTH.
module seq_adder_accum #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             ovf,
    output logic [WIDTH-1:0] acc
);

    localparam int NSTEP = WIDTH / CHUNK;
    localparam int SW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [SW-1:0] LAST = SW'(NSTEP - 1);

`ifdef SEQ_ADDER_ACCUM_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SW-1:0]    step_q, step_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;
    logic             acc_op_q, acc_op_d;

    logic [CHUNK:0]   csum;
    int               idx;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign ovf       = ovf_q;
    assign acc       = acc_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        f_d         = f_q;
        acc_d       = acc_q;
        step_d      = step_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        acc_op_d    = acc_op_q;

        idx  = int'(step_q) * CHUNK;
        csum = {1'b0, x_q[idx +: CHUNK]}
             + {1'b0, y_q[idx +: CHUNK]}
             + {{CHUNK{1'b0}}, carry_q};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    step_d   = '0;
                    acc_op_d = (mode == 2'b10);
                    state_d  = CALC;
                    unique case (mode)
                        2'b00: begin
                            x_d     = a;
                            y_d     = b;
                            carry_d = 1'b0;
                        end
                        2'b01: begin
                            // a - b as a + ~b + 1
                            x_d     = a;
                            y_d     = ~b;
                            carry_d = 1'b1;
                        end
                        2'b10: begin
                            x_d     = acc_q;
                            y_d     = a;
                            carry_d = 1'b0;
                        end
                        default: begin
                            // clear: result is ready on the accepting edge
                            acc_d       = '0;
                            f_d         = '0;
                            ovf_d       = 1'b0;
                            out_valid_d = 1'b1;
                            state_d     = DONE;
                        end
                    endcase
                end
            end
            CALC: begin
                res_d[idx +: CHUNK] = csum[CHUNK-1:0];
                carry_d             = csum[CHUNK];
                step_d              = step_q + 1'b1;
                if (step_q == LAST) begin
                    // MSB-chunk carry-out is dropped; overflow is sign based
                    ovf_d = (x_q[WIDTH-1] == y_q[WIDTH-1])
                         && (res_d[WIDTH-1] != x_q[WIDTH-1]);
`ifdef SEQ_ADDER_ACCUM_SATURATE_EN
                    f_d = ovf_d ? (x_q[WIDTH-1] ? SAT_NEG : SAT_POS) : res_d;
`else
                    f_d = res_d;
`endif
                    if (acc_op_q) begin
                        acc_d = f_d;
                    end
                    carry_d     = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            res_q       <= '0;
            f_q         <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            acc_op_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            res_q       <= res_d;
            f_q         <= f_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            acc_op_q    <= acc_op_d;
        end
    end

endmodule

// File: tb/tb_seq_adder_accum.sv
// tb_seq_adder_accum: directed table plus hand sequences for the 8-bit
// instance, and a 16-bit instance checked against a signed reference model.
module tb_seq_adder_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic       iv8, ir8, ov8, or8, ovf8;
    logic [7:0] a8, b8, f8, acc8;
    logic [1:0] m8;

    logic        iv16, ir16, ov16, or16, ovf16;
    logic [15:0] a16, b16, f16, acc16;
    logic [1:0]  m16;

    int checks   = 0;
    int failures = 0;

    seq_adder_accum #(.WIDTH(8), .CHUNK(4)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8), .mode(m8),
        .out_valid(ov8), .out_ready(or8),
        .f(f8), .ovf(ovf8), .acc(acc8)
    );

    seq_adder_accum #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(iv16), .in_ready(ir16),
        .a(a16), .b(b16), .mode(m16),
        .out_valid(ov16), .out_ready(or16),
        .f(f16), .ovf(ovf16), .acc(acc16)
    );

`ifdef SEQ_ADDER_ACCUM_SATURATE_EN
    localparam logic [7:0]  E_7F01 = 8'h7F;
    localparam logic [7:0]  E_8080 = 8'h80;
    localparam logic [7:0]  E_8001 = 8'h80;
    localparam logic [15:0] E16    = 16'h7FFF;
`else
    localparam logic [7:0]  E_7F01 = 8'h80;
    localparam logic [7:0]  E_8080 = 8'h00;
    localparam logic [7:0]  E_8001 = 8'h7F;
    localparam logic [15:0] E16    = 16'h8000;
`endif

    typedef struct {
        logic [1:0] m;
        logic [7:0] a;
        logic [7:0] b;
        int         hold;
        logic [7:0] f;
        logic       ovf;
        logic [7:0] acc;
    } vec_t;

    vec_t vt[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Issue one op on the 8-bit DUT; optionally stall out_ready for hold
    // cycles while pulsing in_valid, then drain the result.
    task automatic op8(input logic [1:0] m, input logic [7:0] av,
                       input logic [7:0] bv, input int hold,
                       input logic [7:0] ef,
                       output logic [7:0] fo, output logic fovf,
                       output int lat, output logic busy_ok);
        int n;
        n = 0;
        while (!ir8 && n < 100) begin
            tick();
            n++;
        end
        chk("op8_ready", 32'(ir8), 32'd1);
        m8  = m;
        a8  = av;
        b8  = bv;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        a8  = 8'hA5;
        b8  = 8'h5A;
        m8  = 2'b11;
        lat = 1;
        busy_ok = 1'b1;
        while (!ov8 && lat < 100) begin
            if (ir8) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (ir8) busy_ok = 1'b0;
        fo   = f8;
        fovf = ovf8;
        for (int i = 0; i < hold; i++) begin
            iv8 = 1'b1;
            m8  = 2'b00;
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            tick();
            iv8 = 1'b0;
            chk("hold_f", 32'(f8), 32'(ef));
            chk("hold_valid", 32'(ov8), 32'd1);
            chk("hold_ready", 32'(ir8), 32'd0);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("drain_valid", 32'(ov8), 32'd0);
        chk("drain_ready", 32'(ir8), 32'd1);
    endtask

    task automatic op16(input logic [1:0] m, input logic [15:0] av,
                        input logic [15:0] bv,
                        output logic [15:0] fo, output logic fovf,
                        output int lat);
        int n;
        n = 0;
        while (!ir16 && n < 100) begin
            tick();
            n++;
        end
        m16  = m;
        a16  = av;
        b16  = bv;
        iv16 = 1'b1;
        tick();
        iv16 = 1'b0;
        a16  = ~av;
        b16  = ~bv;
        lat  = 1;
        while (!ov16 && lat < 100) begin
            tick();
            lat++;
        end
        fo   = f16;
        fovf = ovf16;
        or16 = 1'b1;
        tick();
        or16 = 1'b0;
    endtask

    function automatic void model16(input logic [1:0] m,
                                    input logic [15:0] av,
                                    input logic [15:0] bv,
                                    output logic [15:0] ef,
                                    output logic eo);
        logic signed [31:0] s;
        if (m == 2'b01) s = $signed(av) - $signed(bv);
        else            s = $signed(av) + $signed(bv);
        eo = (s > 32767) || (s < -32768);
        ef = s[15:0];
`ifdef SEQ_ADDER_ACCUM_SATURATE_EN
        if (s > 32767)  ef = 16'h7FFF;
        if (s < -32768) ef = 16'h8000;
`endif
    endfunction

    initial begin
        logic [7:0]  fo;
        logic [15:0] fo16, ef16;
        logic        fovf, eo16, busy_ok;
        int          lat;
        logic [1:0]  rm;
        logic [15:0] ra, rb;

        vt[0]  = '{2'b00, 8'h05, 8'h03, 0, 8'h08,  1'b0, 8'h00};
        vt[1]  = '{2'b00, 8'h7F, 8'h01, 0, E_7F01, 1'b1, 8'h00};
        vt[2]  = '{2'b00, 8'h0F, 8'h01, 0, 8'h10,  1'b0, 8'h00};
        vt[3]  = '{2'b00, 8'hFF, 8'hFF, 0, 8'hFE,  1'b0, 8'h00};
        vt[4]  = '{2'b00, 8'h80, 8'h80, 0, E_8080, 1'b1, 8'h00};
        vt[5]  = '{2'b01, 8'h80, 8'h01, 0, E_8001, 1'b1, 8'h00};
        vt[6]  = '{2'b01, 8'h10, 8'h10, 0, 8'h00,  1'b0, 8'h00};
        vt[7]  = '{2'b01, 8'h00, 8'h01, 0, 8'hFF,  1'b0, 8'h00};
        vt[8]  = '{2'b11, 8'h55, 8'hAA, 0, 8'h00,  1'b0, 8'h00};
        vt[9]  = '{2'b10, 8'h10, 8'h00, 0, 8'h10,  1'b0, 8'h10};
        vt[10] = '{2'b10, 8'h10, 8'h00, 0, 8'h20,  1'b0, 8'h20};
        vt[11] = '{2'b10, 8'h10, 8'h00, 5, 8'h30,  1'b0, 8'h30};

        rst = 1'b1;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        iv16 = 1'b0; or16 = 1'b0; a16 = '0; b16 = '0; m16 = '0;
        tick();
        tick();
        chk("rst_ready", 32'(ir8), 32'd0);
        chk("rst_f", 32'(f8), 32'd0);
        chk("rst_ovf", 32'(ovf8), 32'd0);
        chk("rst_valid", 32'(ov8), 32'd0);
        chk("rst_acc", 32'(acc8), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(ir8), 32'd1);

        for (int i = 0; i < 12; i++) begin
            op8(vt[i].m, vt[i].a, vt[i].b, vt[i].hold, vt[i].f,
                fo, fovf, lat, busy_ok);
            chk($sformatf("vec%0d_lat", i), 32'(lat),
                (vt[i].m == 2'b11) ? 32'd1 : 32'd3);
            chk($sformatf("vec%0d_f", i), 32'(fo), 32'(vt[i].f));
            chk($sformatf("vec%0d_ovf", i), 32'(fovf), 32'(vt[i].ovf));
            chk($sformatf("vec%0d_acc", i), 32'(acc8), 32'(vt[i].acc));
            chk($sformatf("vec%0d_busy", i), 32'(busy_ok), 32'd1);
        end

        // Reset while a mode-10 op is in CALC with acc = 0x30
        m8  = 2'b10;
        a8  = 8'h10;
        iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        chk("mid_calc_ready", 32'(ir8), 32'd0);
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", 32'(ov8), 32'd0);
        chk("mid_rst_f", 32'(f8), 32'd0);
        chk("mid_rst_acc", 32'(acc8), 32'd0);
        chk("mid_rst_ready", 32'(ir8), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_ready_after", 32'(ir8), 32'd1);
        op8(2'b00, 8'h02, 8'h02, 0, 8'h04, fo, fovf, lat, busy_ok);
        chk("after_rst_f", 32'(fo), 32'h04);
        chk("after_rst_lat", 32'(lat), 32'd3);

        // Accumulator overflow
        op8(2'b10, 8'h7F, 8'h00, 0, 8'h7F, fo, fovf, lat, busy_ok);
        chk("acc7f_acc", 32'(acc8), 32'h7F);
        op8(2'b10, 8'h01, 8'h00, 0, E_7F01, fo, fovf, lat, busy_ok);
        chk("accovf_f", 32'(fo), 32'(E_7F01));
        chk("accovf_ovf", 32'(fovf), 32'd1);
        chk("accovf_acc", 32'(acc8), 32'(E_7F01));

        // 16-bit instance, NSTEP = 4
        op16(2'b00, 16'h7FFF, 16'h0001, fo16, fovf, lat);
        chk("w16_f", 32'(fo16), 32'(E16));
        chk("w16_ovf", 32'(fovf), 32'd1);
        chk("w16_lat", 32'(lat), 32'd5);

        for (int i = 0; i < 500; i++) begin
            rm = 2'($urandom_range(0, 1));
            ra = 16'($urandom);
            rb = 16'($urandom);
            model16(rm, ra, rb, ef16, eo16);
            op16(rm, ra, rb, fo16, fovf, lat);
            chk($sformatf("rnd%0d_f", i), 32'(fo16), 32'(ef16));
            chk($sformatf("rnd%0d_ovf", i), 32'(fovf), 32'(eo16));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
